fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the five-stage pipelined ARM CPU: owns the PC, drives the word address into the
//  instruction memory, and registers the returned instruction into the IF/ID pipeline register.
//  Applies branch/PC-write redirects, hazard-unit stalls and flushes.
//  Also provides a fetch counter and halt flag (branch-to-self, 0xEAFFFFFE) for the testbench.
// PARAMETERS
//  RESET_PC   32'h00000000  PC value loaded on reset
//  NOP_INSTR  32'hE1A00000  bubble inserted into InstrD (MOV r0,r0)
//  HALT_INSTR 32'hEAFFFFFE  encoding that raises HaltD (B .)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  reset         in   1   synchronous, active-high
//  StallF        in   1   hold PC (hazard unit)
//  StallD        in   1   hold IF/ID register
//  FlushD        in   1   replace IF/ID contents with bubble
//  BranchTakenE  in   1   branch resolved taken in EX
//  ALUResultE    in   32  branch target from EX
//  PCSrcW        in   1   instruction in WB writes R15
//  ResultW       in   32  value written to R15 from WB
//  InstrF        in   32  instruction word from imem (combinational read of PCF)
//  PCF           out  32  current fetch address to imem
//  InstrD        out  32  IF/ID instruction
//  PCPlus8D      out  32  IF/ID R15 read value (fetch PC + 8)
//  ValidD        out  1   InstrD is a real fetched instruction (0 = bubble)
//  HaltD         out  1   ValidD && InstrD == HALT_INSTR
//  FetchCount    out  32  number of instructions loaded into IF/ID since reset
// BEHAVIOUR
//  Reset (sync, highest priority): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus8D=0, ValidD=0,
//   FetchCount=0; HaltD=0 as a consequence. Reset mid-stall or mid-redirect discards everything.
//  Next-PC select, priority high->low: BranchTakenE ? ALUResultE : PCSrcW ? ResultW : PCF+4.
//  Redirect targets are forced word-aligned: bits [1:0] cleared. PCF[1:0] is always 2'b00.
//  PC register: a redirect (BranchTakenE|PCSrcW) loads the PC even if StallF=1.
//   Otherwise StallF=1 holds PCF; StallF=0 loads PCF+4. PC+4 wraps modulo 2^32.
//  IF/ID register, priority high->low:
//   reset; FlushD=1 -> InstrD=NOP_INSTR, ValidD=0, PCPlus8D=0 (FlushD wins over StallD);
//   StallD=1 -> hold all IF/ID fields; else -> InstrD=InstrF, PCPlus8D=PCF+8, ValidD=1.
//  Fetch latency: an instruction at PCF in cycle n appears on InstrD in cycle n+1 (1 cycle).
//  FetchCount increments by 1 exactly on cycles where IF/ID loads (not reset, not FlushD,
//   not StallD). Wraps 0xFFFFFFFF -> 0. Bubbles never count.
//  HaltD is combinational from the registered InstrD/ValidD. It does not stop fetch; the
//   sequencer sees the branch-to-self loop.
//  The hazard unit must assert FlushD alongside any redirect; this block does not self-flush.
//  No other state. There is no handshake with imem: reads are assumed single-cycle combinational.
// TESTING
//  1 Reset, then free run, imem word0=E3A0000A: PCF=0,4,8... InstrD=E3A0000A, PCPlus8D=8,
//    ValidD=1 one cycle after reset is released.
//  2 StallF=StallD=1 for 2 cycles at PCF=0x10: PCF, InstrD and FetchCount frozen; they
//    resume at 0x14 afterwards.
//  3 BranchTakenE=1, ALUResultE=0x44, FlushD=1: next PCF=0x44, InstrD=E1A00000, ValidD=0,
//    count unchanged.
//  4 BranchTakenE=1 (0x20) with PCSrcW=1 (0x38) in the same cycle -> PCF=0x20.
//    PCSrcW alone with ResultW=0x47 -> PCF=0x44.
//  5 Redirect with StallF=1 -> PCF takes target. FlushD+StallD together -> bubble.
//  6 Fetch EAFFFFFE -> HaltD=1 next cycle. Assert reset while StallD=1 -> PCF=0, ValidD=0,
//    FetchCount=0, HaltD=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the five-stage ARM pipeline.
// Owns the PC, presents the word address to the combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
// Also keeps a fetch counter and flags the branch-to-self halt idiom.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000,
    parameter logic [31:0] HALT_INSTR = 32'hEAFF_FFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        HaltD,
    output logic [31:0] FetchCount
);

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [31:0] pc_plus4_s;
    logic [31:0] pc_plus8_s;
    logic [31:0] target_s;
    logic [31:0] pc_next_s;
    logic        redirect_s;
    logic        load_d_s;

    assign pc_plus4_s = PCF + 32'd4;
    assign pc_plus8_s = PCF + 32'd8;
    assign redirect_s = BranchTakenE | PCSrcW;
    assign load_d_s   = ~FlushD & ~StallD;

    // Next-PC select: EX branch beats WB write to R15, redirects beat a stall.
    always_comb begin
        target_s  = pc_plus4_s;
        pc_next_s = PCF;
        if (BranchTakenE) begin
            target_s = word_align(ALUResultE);
        end else if (PCSrcW) begin
            target_s = word_align(ResultW);
        end else begin
            target_s = pc_plus4_s;
        end

        if (redirect_s) begin
            pc_next_s = target_s;
        end else if (StallF) begin
            pc_next_s = PCF;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            PCF <= word_align(RESET_PC);
        end else begin
            PCF <= pc_next_s;
        end
    end

    // IF/ID pipeline register: a flush bubble takes precedence over a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= NOP_INSTR;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCPlus8D <= PCPlus8D;
            ValidD   <= ValidD;
        end else begin
            InstrD   <= InstrF;
            PCPlus8D <= pc_plus8_s;
            ValidD   <= 1'b1;
        end
    end

    // Counts real instructions entering IF/ID; bubbles and held cycles do not count.
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCount <= 32'd0;
        end else if (load_d_s) begin
            FetchCount <= FetchCount + 32'd1;
        end else begin
            FetchCount <= FetchCount;
        end
    end

    // Halt marker decoded from the registered IF/ID contents only.
    assign HaltD = ValidD && (InstrD == HALT_INSTR);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural reference model predicts
// the state after every clock, the prediction is queued when the stimulus is
// applied and popped for comparison once the clock edge has happened.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'hE1A0_0000;
    localparam logic [31:0] HALT = 32'hEAFF_FFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        BranchTakenE = 1'b0;
    logic [31:0] ALUResultE = 32'd0;
    logic        PCSrcW = 1'b0;
    logic [31:0] ResultW = 32'd0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        ValidD;
    logic        HaltD;
    logic [31:0] FetchCount;

    logic [31:0] mem [64];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p8;
        logic [31:0] cnt;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_p8    = 32'd0;
    logic [31:0] m_cnt   = 32'd0;
    logic        m_valid = 1'b0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
        .ResultW(ResultW), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD),
        .PCPlus8D(PCPlus8D), .ValidD(ValidD), .HaltD(HaltD), .FetchCount(FetchCount)
    );

    // combinational instruction memory
    assign InstrF = mem[PCF[7:2]];

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, predict, clock, then compare against the queue.
    task automatic cycle(input logic rst, input logic sf, input logic sd, input logic fd,
                         input logic bt, input logic [31:0] alu,
                         input logic pw, input logic [31:0] res);
        exp_t e;
        exp_t g;
        logic [31:0] tgt;
        reset = rst; StallF = sf; StallD = sd; FlushD = fd;
        BranchTakenE = bt; ALUResultE = alu; PCSrcW = pw; ResultW = res;
        if (rst) begin
            m_pc = 32'd0; m_instr = NOP; m_p8 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
        end else begin
            if (fd) begin
                m_instr = NOP; m_p8 = 32'd0; m_valid = 1'b0;
            end else if (!sd) begin
                m_instr = mem[m_pc[7:2]]; m_p8 = m_pc + 32'd8; m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
            tgt = bt ? alu : res;
            tgt[1:0] = 2'b00;
            if (bt || pw) m_pc = tgt;
            else if (!sf) m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.instr = m_instr; e.p8 = m_p8; e.cnt = m_cnt;
        e.valid = m_valid; e.halt = m_valid && (m_instr == HALT);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check_value("pcf", PCF, g.pc);
        check_value("instr_d", InstrD, g.instr);
        check_value("pcplus8_d", PCPlus8D, g.p8);
        check_value("valid_d", {31'd0, ValidD}, {31'd0, g.valid});
        check_value("halt_d", {31'd0, HaltD}, {31'd0, g.halt});
        check_value("fetch_count", FetchCount, g.cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {16'hE3A0, 4'h1, i[11:0]};
        mem[0]  = 32'hE3A0_000A;
        mem[12] = HALT;

        // reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_value("rst_pcf", PCF, 32'd0);
        check_value("rst_instr", InstrD, NOP);
        check_value("rst_count", FetchCount, 32'd0);

        // free run from reset
        run(1);
        check_value("first_instr", InstrD, 32'hE3A0_000A);
        check_value("first_pc8", PCPlus8D, 32'd8);
        check_value("first_valid", {31'd0, ValidD}, 32'd1);
        check_value("first_pcf", PCF, 32'd4);
        run(3);
        check_value("pcf_at_10", PCF, 32'h10);

        // stall both F and D for two cycles
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_value("stall_pcf", PCF, 32'h10);
        check_value("stall_count", FetchCount, 32'd4);
        run(1);
        check_value("resume_pcf", PCF, 32'h14);

        // taken branch with flush
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 32'd0);
        check_value("br_pcf", PCF, 32'h44);
        check_value("br_bubble", InstrD, NOP);
        check_value("br_count", FetchCount, 32'd5);

        // branch beats PCSrcW; PCSrcW alone is aligned
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h38);
        check_value("prio_pcf", PCF, 32'h20);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h47);
        check_value("pcsrcw_pcf", PCF, 32'h44);
        run(2);

        // redirect while StallF; flush together with StallD
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'd0);
        check_value("stallf_redirect", PCF, 32'h80);
        run(1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        check_value("flush_over_stall", {31'd0, ValidD}, 32'd0);

        // halt detection, then reset while StallD
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0, 32'd0);
        run(1);
        check_value("halt_seen", {31'd0, HaltD}, 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_value("rst2_pcf", PCF, 32'd0);
        check_value("rst2_halt", {31'd0, HaltD}, 32'd0);
        check_value("rst2_count", FetchCount, 32'd0);

        // PC wraps past the top of the address space
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0);
        check_value("wrap_top", PCF, 32'hFFFF_FFFC);
        run(1);
        check_value("wrap_zero", PCF, 32'd0);
        check_value("wrap_pc8", PCPlus8D, 32'h0000_0004);

        // randomised control mix
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 9) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
